// File: rtl/ct_encrypt.sv
// ARC4 encryptor over an external 256x8 S-array: INIT, KSA (4 cyc/iter), LEN, PRGA (7 cyc/byte); optional ARC4_PRINTABLE_CHECK_EN.
// One run per en while rdy=1; en while busy is ignored; rdy returns on the edge after the last ct write.
module ct_encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic        pt_err
);

    typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA} state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]  si_q, si_d, sj_q, sj_d, t_q, t_d, ptb_q, ptb_d;
    logic [1:0]  km_q, km_d;
    logic [23:0] key_q, key_d;
    logic        rdy_q, rdy_d;
    logic [7:0]  s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic        s_wren_q, s_wren_d;
    logic [7:0]  pt_addr_q, pt_addr_d;
    logic [7:0]  ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic        ct_wren_q, ct_wren_d;
    logic [7:0]  kbyte, jn, pad;
    logic        start;

    assign start = (state_q == IDLE) && rdy_q && en;

    always_comb begin
        case (km_q)
            2'd0:    kbyte = key_q[23:16];
            2'd1:    kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        len_d      = len_q;
        si_d       = si_q;
        sj_d       = sj_q;
        t_d        = t_q;
        ptb_d      = ptb_q;
        km_d       = km_q;
        key_d      = key_q;
        rdy_d      = rdy_q;
        s_addr_d   = s_addr_q;
        s_wrdata_d = s_wrdata_q;
        s_wren_d   = 1'b0;
        pt_addr_d  = pt_addr_q;
        ct_addr_d  = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d  = 1'b0;
        jn         = 8'd0;
        pad        = 8'd0;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (start) begin
                    key_d   = key;
                    rdy_d   = 1'b0;
                    state_d = INIT;
                    i_d     = 8'd0;
                end
            end
            INIT: begin
                s_addr_d   = i_q;
                s_wrdata_d = i_q;
                s_wren_d   = 1'b1;
                i_d        = i_q + 8'd1;
                if (i_q == 8'hFF) begin
                    // s[0] is known to be 0 after INIT, so the first KSA read is skipped
                    state_d = KSA;
                    phase_d = 3'd0;
                    j_d     = 8'd0;
                    si_d    = 8'd0;
                    km_d    = 2'd0;
                end
            end
            KSA: begin
                case (phase_q)
                    3'd0: begin
                        jn       = j_q + si_q + kbyte;
                        j_d      = jn;
                        s_addr_d = jn;
                        phase_d  = 3'd1;
                    end
                    3'd1: begin
                        s_addr_d = i_q + 8'd1;
                        phase_d  = 3'd2;
                    end
                    3'd2: begin
                        s_addr_d   = i_q;
                        s_wrdata_d = s_rddata;
                        s_wren_d   = 1'b1;
                        phase_d    = 3'd3;
                    end
                    default: begin
                        s_addr_d   = j_q;
                        s_wrdata_d = si_q;
                        s_wren_d   = 1'b1;
                        // prefetched s[i+1] is stale when this swap lands on it
                        si_d       = (j_q == i_q + 8'd1) ? si_q : s_rddata;
                        i_d        = i_q + 8'd1;
                        km_d       = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
                        phase_d    = 3'd0;
                        if (i_q == 8'hFF) state_d = LEN;
                    end
                endcase
            end
            LEN: begin
                case (phase_q)
                    3'd0: begin
                        pt_addr_d = 8'd0;
                        phase_d   = 3'd1;
                    end
                    3'd1: phase_d = 3'd2;
                    3'd2: begin
                        len_d       = pt_rddata;
                        ct_addr_d   = 8'd0;
                        ct_wrdata_d = pt_rddata;
                        ct_wren_d   = 1'b1;
                        if (pt_rddata == 8'd0) begin
                            phase_d = 3'd3;
                        end else begin
                            state_d = PRGA;
                            phase_d = 3'd0;
                            k_d     = 8'd1;
                            i_d     = 8'd0;
                            j_d     = 8'd0;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                    end
                endcase
            end
            PRGA: begin
                case (phase_q)
                    3'd0: begin
                        i_d       = i_q + 8'd1;
                        s_addr_d  = i_q + 8'd1;
                        pt_addr_d = k_q;
                        phase_d   = 3'd1;
                    end
                    3'd1: phase_d = 3'd2;
                    3'd2: begin
                        si_d     = s_rddata;
                        jn       = j_q + s_rddata;
                        j_d      = jn;
                        s_addr_d = jn;
                        ptb_d    = pt_rddata;
                        phase_d  = 3'd3;
                    end
                    3'd3: phase_d = 3'd4;
                    3'd4: begin
                        sj_d     = s_rddata;
                        t_d      = si_q + s_rddata;
                        s_addr_d = si_q + s_rddata;
                        phase_d  = 3'd5;
                    end
                    3'd5: begin
                        s_addr_d   = i_q;
                        s_wrdata_d = sj_q;
                        s_wren_d   = 1'b1;
                        phase_d    = 3'd6;
                    end
                    3'd6: begin
                        s_addr_d   = j_q;
                        s_wrdata_d = si_q;
                        s_wren_d   = 1'b1;
                        // pad was read before the swap landed; forward swapped values
                        if (t_q == i_q)      pad = sj_q;
                        else if (t_q == j_q) pad = si_q;
                        else                 pad = s_rddata;
                        ct_addr_d   = k_q;
                        ct_wrdata_d = ptb_q ^ pad;
                        ct_wren_d   = 1'b1;
                        k_d         = k_q + 8'd1;
                        phase_d     = (k_q == len_q) ? 3'd7 : 3'd0;
                    end
                    default: begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            t_q         <= 8'd0;
            ptb_q       <= 8'd0;
            km_q        <= 2'd0;
            key_q       <= 24'd0;
            rdy_q       <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            s_wren_q    <= 1'b0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            t_q         <= t_d;
            ptb_q       <= ptb_d;
            km_q        <= km_d;
            key_q       <= key_d;
            rdy_q       <= rdy_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
    end

`ifdef ARC4_PRINTABLE_CHECK_EN
    logic pt_err_q, pt_err_d;

    always_comb begin
        pt_err_d = pt_err_q;
        if (start)
            pt_err_d = 1'b0;
        else if (state_q == PRGA && phase_q == 3'd6 && (ptb_q < 8'h20 || ptb_q > 8'h7E))
            pt_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pt_err_q <= 1'b0;
        else     pt_err_q <= pt_err_d;
    end

    assign pt_err = pt_err_q;
`else
    assign pt_err = 1'b0;
`endif

    assign rdy       = rdy_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

endmodule
